mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port unified memory between the rv32i_top IF stage (instruction fetch) and MEM stage (load/store).
//  - Runs one memory transaction at a time.
//  - Drives per-requester stall signals back into the pipeline.
//  - Drops fetches squashed by a taken branch/jump (PCsrc).
//  - Bounds every access with a timeout.
//  Sits between the pipeline stage logic and the memory macro.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width (wstrb width = DW/8)
//  TIMEOUT  16  cycles in BUSY without mem_ready before abort; 0 disables timeout
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  if_req     in   1      fetch request; level, held until if_done
//  if_addr    in   AW     fetch address
//  if_flush   in   1      squash the current fetch (branch/jump taken)
//  if_rdata   out  DW     fetched instruction, valid while if_done=1
//  if_done    out  1      one-cycle fetch completion pulse
//  if_stall   out  1      = if_req & ~if_done (combinational)
//  d_req      in   1      data request; level, held until d_done
//  d_we       in   1      1=store, 0=load
//  d_addr     in   AW     data address
//  d_wdata    in   DW     store data
//  d_wstrb    in   DW/8   store byte enables
//  d_rdata    out  DW     load data, valid while d_done=1; 0 for stores
//  d_done     out  1      one-cycle data completion pulse
//  d_stall    out  1      = d_req & ~d_done (combinational)
//  mem_req    out  1      memory request, registered
//  mem_we     out  1      memory write enable, registered
//  mem_addr   out  AW     memory address, registered
//  mem_wdata  out  DW     memory write data, registered
//  mem_wstrb  out  DW/8   memory byte strobes, registered; 0 on reads
//  mem_ready  in   1      memory completes the access in this cycle; mem_rdata valid
//  mem_rdata  in   DW     memory read data
//  bus_err    out  1      one-cycle pulse on timeout abort
// BEHAVIOUR
//  States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
//  Reset (async, any state): state=IDLE, last_grant=FETCH, drop=0, all outputs 0 immediately.
//    Any in-flight transaction is abandoned.
//  IDLE arbitration:
//    - Both if_req (with if_flush=0) and d_req pending: data wins, unless last_grant=DATA, then fetch wins.
//    - Only one pending: grant that one.
//    - if_req with if_flush=1 in the same cycle is ignored.
//  On grant:
//    - mem_* are loaded from the granted requester's inputs at the edge; mem_req=1 from the next cycle.
//    - last_grant is updated.
//    - The timeout counter is cleared.
//  BUSY_x:
//    - mem_req and all mem_* are held stable.
//    - On mem_ready=1: capture mem_rdata (0 for stores), mem_req=0, go to RESP_x.
//  Timeout:
//    - Applies when TIMEOUT>0 and the counter reaches TIMEOUT in BUSY with mem_ready=0.
//    - mem_req=0, bus_err=1 for 1 cycle, captured data=0, go to RESP_x.
//    - The requester still gets done, so the pipeline never hangs.
//  RESP_x:
//    - x_done=1 and x_rdata=captured data for exactly 1 cycle.
//    - No grant is made in this cycle, because the requester's old req is still visible.
//    - Next state is IDLE.
//  Latency: req in IDLE at edge k; mem_req high in cycle k+1; mem_ready in cycle k+1 -> done in cycle k+2.
//    Minimum occupancy is 3 cycles per access.
//  Flush:
//    - if_flush=1 in BUSY_I or RESP_I sets drop; the bus access still completes normally.
//    - if_done is forced 0 for that transaction; drop clears on entry to IDLE.
//    - if_flush has no effect on data transactions.
//  mem_ready outside BUSY is ignored.
//  x_done is never asserted in a cycle where x_req=0.
//  The timeout counter saturates and does not wrap.
//  Requester inputs changing during BUSY do not affect mem_*; the request was latched at grant.
// TESTING
//  1 Load only: d_req, d_we=0, d_addr=0x100; mem_ready 2 cycles after mem_req, rdata=0xDEADBEEF
//    -> mem_req high 2 cycles; d_done 1 cycle later with d_rdata=0xDEADBEEF; d_stall low in the done cycle.
//  2 Both requests at once after reset -> data granted first (mem_addr=d_addr), then fetch.
//    Both requests held again after that -> fetch is granted before data (alternation).
//  3 Store: d_we=1, d_wdata=0x12345678, d_wstrb=4'b0011 -> mem_we=1, mem_wstrb=0011, d_done with d_rdata=0.
//  4 Fetch at 0x40, then if_flush in BUSY_I -> access completes on the bus; if_done stays 0; arbiter returns to IDLE.
//  5 TIMEOUT=16, mem_ready held 0 -> mem_req drops after 16 BUSY cycles.
//    bus_err=1 for 1 cycle; done with rdata=0.
//  6 Assert reset during BUSY_D -> mem_req, d_done and bus_err go 0 at once (async).
//    After release, a new d_req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-port unified memory between the instruction
//             fetch (IF) and load/store (MEM) stages. One transaction runs at
//             a time. Completion is reported as a one-cycle done pulse.
//             Squashed fetches are dropped. Each access is bounded by a
//             timeout.
//  Ports    : clk, reset (async, active-high)
//             if_*  : fetch requester  (req/addr/flush -> rdata/done/stall)
//             d_*   : data requester   (req/we/addr/wdata/wstrb -> rdata/done/stall)
//             mem_* : registered memory request, mem_ready/mem_rdata back
//             bus_err : one-cycle pulse when an access is aborted by timeout
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic [DW-1:0]   if_rdata,
    output logic            if_done,
    output logic            if_stall,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic [DW-1:0]   d_rdata,
    output logic            d_done,
    output logic            d_stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic            bus_err
);

    localparam int SW = DW / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Counter value seen in the last BUSY cycle allowed before abort.
    localparam logic [CW-1:0] C_TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_BUSY_I = 3'd1,
        S_BUSY_D = 3'd2,
        S_RESP_I = 3'd3,
        S_RESP_D = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_data;   // 1: previous grant went to data port
    logic            r_drop;        // current fetch was squashed
    logic [CW-1:0]   r_tmo_cnt;
    logic [DW-1:0]   r_rdata;

    logic            w_if_ok;
    logic            w_busy;
    logic            w_tmo;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_ready_hit;
    logic            w_tmo_hit;

    // A fetch flushed in the same cycle is already dead; never grant it.
    assign w_if_ok = if_req & ~if_flush;
    assign w_busy  = (r_state == S_BUSY_I) || (r_state == S_BUSY_D);
    assign w_tmo   = (TIMEOUT != 0) && (r_tmo_cnt >= C_TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and transaction events
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_ready_hit = 1'b0;
        w_tmo_hit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Data has priority unless it won last time (alternation).
                if (d_req && (!w_if_ok || !r_last_data)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = S_BUSY_D;
                end else if (w_if_ok) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = S_BUSY_I;
                end
            end
            S_BUSY_I, S_BUSY_D: begin
                if (mem_ready) begin
                    w_ready_hit = 1'b1;
                    w_state_nxt = (r_state == S_BUSY_I) ? S_RESP_I : S_RESP_D;
                end else if (w_tmo) begin
                    w_tmo_hit   = 1'b1;
                    w_state_nxt = (r_state == S_BUSY_I) ? S_RESP_I : S_RESP_D;
                end
            end
            // Requester's old req is still visible here, so no grant.
            S_RESP_I, S_RESP_D: w_state_nxt = S_IDLE;
            default:            w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory request, captured data, bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wstrb   <= '0;
            r_rdata     <= '0;
            bus_err     <= 1'b0;
            r_last_data <= 1'b0;
            r_drop      <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            bus_err <= w_tmo_hit;
            if (w_grant_d) begin
                mem_req     <= 1'b1;
                mem_we      <= d_we;
                mem_addr    <= d_addr;
                mem_wdata   <= d_wdata;
                mem_wstrb   <= d_we ? d_wstrb : {SW{1'b0}};
                r_last_data <= 1'b1;
                r_tmo_cnt   <= '0;
            end else if (w_grant_i) begin
                mem_req     <= 1'b1;
                mem_we      <= 1'b0;
                mem_addr    <= if_addr;
                mem_wdata   <= '0;
                mem_wstrb   <= '0;
                r_last_data <= 1'b0;
                r_tmo_cnt   <= '0;
            end else if (w_ready_hit) begin
                mem_req <= 1'b0;
                r_rdata <= mem_we ? '0 : mem_rdata;
            end else if (w_tmo_hit) begin
                mem_req <= 1'b0;
                r_rdata <= '0;
            end else if (w_busy && !(&r_tmo_cnt)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_state_nxt == S_IDLE) begin
                r_drop <= 1'b0;
            end else if (if_flush && ((r_state == S_BUSY_I) || (r_state == S_RESP_I))) begin
                r_drop <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Requester responses. A flush arriving in the response cycle itself
    // must also suppress the done pulse, hence the direct if_flush term.
    // ------------------------------------------------------------------
    assign if_done  = (r_state == S_RESP_I) & ~r_drop & ~if_flush & if_req;
    assign d_done   = (r_state == S_RESP_D) & d_req;
    assign if_rdata = if_done ? r_rdata : '0;
    assign d_rdata  = d_done ? r_rdata : '0;
    assign if_stall = if_req & ~if_done;
    assign d_stall  = d_req & ~d_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, if_done, if_stall;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_done, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        mem_req, mem_we, mem_ready, bus_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs change and outputs are sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_addr = 0; if_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
        mem_ready = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        clear_inputs();
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wstrb !== 4'h0) begin failures++; $display("FAIL reset_mem_wstrb: got %h want 0", mem_wstrb); end
        checks++; if ({if_done, d_done, bus_err} !== 3'b000) begin failures++; $display("FAIL reset_done_err: got %b want 000", {if_done, d_done, bus_err}); end
    endtask

    task automatic test_load();
        d_req = 1; d_we = 0; d_addr = 32'h100;
        tick();  // grant edge; first mem_req cycle
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin failures++; $display("FAIL load_issue: got req=%b addr=%h we=%b want 1/100/0", mem_req, mem_addr, mem_we); end
        checks++; if (d_stall !== 1'b1) begin failures++; $display("FAIL load_stall_busy: got %b want 1", d_stall); end
        tick();  // second mem_req cycle
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL load_req_held: got %b want 1", mem_req); end
        mem_ready = 1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 0; mem_rdata = 0;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL load_done: got done=%b rdata=%h want 1/deadbeef", d_done, d_rdata); end
        checks++; if (d_stall !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL load_done_stall: got stall=%b req=%b want 0/0", d_stall, mem_req); end
        d_req = 0;
        tick();
        checks++; if (d_done !== 1'b0) begin failures++; $display("FAIL load_done_pulse: got %b want 0", d_done); end
    endtask

    task automatic test_arbitration();
        do_reset();
        if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h200;
        tick();
        checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL arb_data_first: got %h want 200", mem_addr); end
        checks++; if (if_stall !== 1'b1) begin failures++; $display("FAIL arb_if_stall: got %b want 1", if_stall); end
        mem_ready = 1; mem_rdata = 32'hA5A50001;
        tick();
        mem_ready = 0;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'hA5A50001 || if_done !== 1'b0) begin failures++; $display("FAIL arb_d_resp: got done=%b rdata=%h ifdone=%b", d_done, d_rdata, if_done); end
        d_addr = 32'h204;  // next data request already waiting
        tick();            // RESP -> IDLE, no grant
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL arb_no_grant_in_resp: got %b want 0", mem_req); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin failures++; $display("FAIL arb_fetch_alternate: got req=%b addr=%h want 1/40", mem_req, mem_addr); end
        mem_ready = 1; mem_rdata = 32'h00000013;
        tick();
        mem_ready = 0;
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h13 || d_done !== 1'b0) begin failures++; $display("FAIL arb_i_resp: got done=%b rdata=%h ddone=%b", if_done, if_rdata, d_done); end
        if_addr = 32'h44;
        tick();
        tick();
        checks++; if (mem_addr !== 32'h204) begin failures++; $display("FAIL arb_data_alternate: got %h want 204", mem_addr); end
        mem_ready = 1; mem_rdata = 32'h7;
        tick();
        mem_ready = 0;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h7) begin failures++; $display("FAIL arb_d_resp2: got done=%b rdata=%h want 1/7", d_done, d_rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = 32'h12345678; d_wstrb = 4'b0011;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_wstrb !== 4'b0011 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL store_issue: got we=%b strb=%b wdata=%h", mem_we, mem_wstrb, mem_wdata); end
        d_wdata = 32'hFFFFFFFF; d_addr = 32'h999;  // changes after grant must not leak
        mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
        #1;
        checks++; if (mem_wdata !== 32'h12345678 || mem_addr !== 32'h300) begin failures++; $display("FAIL store_latched: got wdata=%h addr=%h", mem_wdata, mem_addr); end
        tick();
        mem_ready = 0;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL store_done: got done=%b rdata=%h want 1/0", d_done, d_rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_flush();
        if_req = 1; if_addr = 32'h40;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin failures++; $display("FAIL flush_issue: got req=%b addr=%h", mem_req, mem_addr); end
        if_flush = 1;
        tick();
        if_flush = 0;
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL flush_bus_continues: got %b want 1", mem_req); end
        mem_ready = 1; mem_rdata = 32'h11111111;
        tick();
        mem_ready = 0;
        checks++; if (if_done !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL flush_no_done: got done=%b req=%b want 0/0", if_done, mem_req); end
        if_req = 0;
        tick();
        checks++; if (mem_req !== 1'b0 || if_done !== 1'b0) begin failures++; $display("FAIL flush_idle: got req=%b done=%b", mem_req, if_done); end
        if_req = 1; if_addr = 32'h44;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin failures++; $display("FAIL flush_refetch: got req=%b addr=%h", mem_req, mem_addr); end
        mem_ready = 1; mem_rdata = 32'h22222222;
        tick();
        mem_ready = 0;
        checks++; if (if_done !== 1'b1 || if_rdata !== 32'h22222222) begin failures++; $display("FAIL flush_refetch_done: got done=%b rdata=%h", if_done, if_rdata); end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int high_cnt;
        d_req = 1; d_we = 0; d_addr = 32'h500;
        tick();
        high_cnt = mem_req ? 1 : 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (mem_req) high_cnt++;
            checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL tmo_early_err: cycle %0d got %b want 0", i, bus_err); end
        end
        checks++; if (high_cnt !== 16) begin failures++; $display("FAIL tmo_busy_cycles: got %0d want 16", high_cnt); end
        tick();
        checks++; if (mem_req !== 1'b0 || bus_err !== 1'b1) begin failures++; $display("FAIL tmo_abort: got req=%b err=%b want 0/1", mem_req, bus_err); end
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'h0) begin failures++; $display("FAIL tmo_done: got done=%b rdata=%h want 1/0", d_done, d_rdata); end
        d_req = 0;
        tick();
        checks++; if (bus_err !== 1'b0 || d_done !== 1'b0) begin failures++; $display("FAIL tmo_pulse: got err=%b done=%b want 0/0", bus_err, d_done); end
    endtask

    task automatic test_async_reset();
        d_req = 1; d_we = 0; d_addr = 32'h600;
        tick();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL areset_busy: got %b want 1", mem_req); end
        #2;
        reset = 1;
        #1;
        checks++; if (mem_req !== 1'b0 || d_done !== 1'b0 || bus_err !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL areset_immediate: got req=%b done=%b err=%b addr=%h", mem_req, d_done, bus_err, mem_addr); end
        tick();
        reset = 0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h600) begin failures++; $display("FAIL areset_regrant: got req=%b addr=%h", mem_req, mem_addr); end
        mem_ready = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 0;
        checks++; if (d_done !== 1'b1 || d_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL areset_done: got done=%b rdata=%h", d_done, d_rdata); end
        clear_inputs();
        tick();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_load();
        test_arbitration();
        test_store();
        test_flush();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
